// File: rtl/game_pkg.sv
// ============================================================================
// Module      : game_pkg
// Description : Shared definitions for the whack-a-mole game-flow controller:
//               phase encodings, default timing constants and points-per-hit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package game_pkg;

    // Phase encoding, also exported on the phase port.
    typedef enum logic [1:0] {
        PH_IDLE      = 2'b00,
        PH_COUNTDOWN = 2'b01,
        PH_PLAY      = 2'b10,
        PH_OVER      = 2'b11
    } phase_t;

    // Default timing, in seconds. Both must lie in 1..63 to fit time_left.
    localparam int DEF_COUNTDOWN_S = 5;
    localparam int DEF_GAME_S      = 30;

    // Default score register width.
    localparam int DEF_SCORE_W     = 16;

    // Points awarded per correct whack.
    localparam int PTS_SLOW        = 1;
    localparam int PTS_FAST        = 2;

endpackage : game_pkg

`default_nettype wire

// File: rtl/game_sequencer_rise_detect.sv
// ============================================================================
// Module      : rise_detect
// Description : Single-bit registered rising-edge detector.
//               rise = d & ~d_q, where d_q is the previous-cycle copy of d.
//   Ports:
//     clk    in   clock
//     reset  in   synchronous active-low reset
//     d      in   level input (already debounced/synchronised)
//     rise   out  one-cycle pulse on a 0->1 transition of d
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic r_d_q;

    // During reset the history is forced to "high", so a level that is
    // already asserted when reset releases is not mistaken for a new press;
    // the input must drop and rise again before a pulse is produced.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_d_q <= 1'b1;
        end else begin
            r_d_q <= d;
        end
    end

    assign rise = d & ~r_d_q;

endmodule : rise_detect

`default_nettype wire

// File: rtl/game_sequencer.sv
// ============================================================================
// Module      : game_sequencer
// Description : Game-flow controller. Sequences IDLE -> COUNTDOWN -> PLAY ->
//               OVER, owns the score / high-score registers, gates the mole
//               generator and selects the value shown on the display.
//   Ports:
//     clk            in   100 MHz system clock
//     reset          in   synchronous active-low reset
//     start          in   debounced start button (level, rising edge used)
//     tick_1hz       in   one-cycle pulse per second
//     hit            in   one-cycle pulse per correct whack
//     level_select   in   0 = slow, 1 = fast; sampled on start
//     phase          out  current phase (game_pkg::phase_t encoding)
//     time_left      out  seconds remaining in the current timed phase
//     score          out  current game score
//     high_score     out  best score since reset
//     new_record     out  high in OVER when the last game beat high_score
//     mole_enable    out  high only in PLAY
//     level_fast     out  level latched at start
//     display_value  out  zero-extended value for the binary-to-BCD path
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_sequencer
    import game_pkg::*;
#(
    parameter int COUNTDOWN_S = DEF_COUNTDOWN_S,
    parameter int GAME_S      = DEF_GAME_S,
    parameter int SCORE_W     = DEF_SCORE_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               tick_1hz,
    input  logic               hit,
    input  logic               level_select,
    output logic [1:0]         phase,
    output logic [5:0]         time_left,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic               new_record,
    output logic               mole_enable,
    output logic               level_fast,
    output logic [31:0]        display_value
);

    localparam logic [5:0]         c_countdown_s = 6'(COUNTDOWN_S);
    localparam logic [5:0]         c_game_s      = 6'(GAME_S);
    localparam logic [SCORE_W-1:0] c_score_max   = {SCORE_W{1'b1}};

    // ------------------------------------------------------------------------
    // Start button edge detection
    // ------------------------------------------------------------------------
    logic w_start_rise;

    rise_detect u_start_rise (
        .clk   (clk),
        .reset (reset),
        .d     (start),
        .rise  (w_start_rise)
    );

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    phase_t             r_phase;
    logic [5:0]         r_time_left;
    logic [SCORE_W-1:0] r_score;
    logic [SCORE_W-1:0] r_high_score;
    logic               r_new_record;
    logic               r_level_fast;

    phase_t             w_phase_nx;
    logic [5:0]         w_time_left_nx;
    logic [SCORE_W-1:0] w_score_nx;
    logic [SCORE_W-1:0] w_high_score_nx;
    logic               w_new_record_nx;
    logic               w_level_fast_nx;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_phase      <= PH_IDLE;
            r_time_left  <= '0;
            r_score      <= '0;
            r_high_score <= '0;
            r_new_record <= 1'b0;
            r_level_fast <= 1'b0;
        end else begin
            r_phase      <= w_phase_nx;
            r_time_left  <= w_time_left_nx;
            r_score      <= w_score_nx;
            r_high_score <= w_high_score_nx;
            r_new_record <= w_new_record_nx;
            r_level_fast <= w_level_fast_nx;
        end
    end

    // ------------------------------------------------------------------------
    // Saturating score increment. One extra bit catches the overflow.
    // ------------------------------------------------------------------------
    logic [SCORE_W:0]   w_pts;
    logic [SCORE_W:0]   w_sum;
    logic [SCORE_W-1:0] w_score_inc;

    always_comb begin
        w_pts       = r_level_fast ? (SCORE_W+1)'(PTS_FAST) : (SCORE_W+1)'(PTS_SLOW);
        w_sum       = {1'b0, r_score} + w_pts;
        w_score_inc = w_sum[SCORE_W] ? c_score_max : w_sum[SCORE_W-1:0];
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_phase_nx      = r_phase;
        w_time_left_nx  = r_time_left;
        w_score_nx      = r_score;
        w_high_score_nx = r_high_score;
        w_new_record_nx = r_new_record;
        w_level_fast_nx = r_level_fast;

        case (r_phase)
            // A tick coincident with the start edge is simply not looked at
            // here, so the countdown always begins from its full value.
            PH_IDLE, PH_OVER: begin
                if (w_start_rise) begin
                    w_phase_nx      = PH_COUNTDOWN;
                    w_time_left_nx  = c_countdown_s;
                    w_score_nx      = '0;
                    w_new_record_nx = 1'b0;
                    w_level_fast_nx = level_select;
                end
            end

            PH_COUNTDOWN: begin
                if (tick_1hz) begin
                    if (r_time_left > 6'd1) begin
                        w_time_left_nx = r_time_left - 6'd1;
                    end else begin
                        w_phase_nx     = PH_PLAY;
                        w_time_left_nx = c_game_s;
                    end
                end
            end

            PH_PLAY: begin
                if (hit) begin
                    w_score_nx = w_score_inc;
                end
                if (tick_1hz) begin
                    if (r_time_left > 6'd1) begin
                        w_time_left_nx = r_time_left - 6'd1;
                    end else begin
                        // Record check uses the post-hit score so a hit on
                        // the final tick counts, and the record flag appears
                        // together with the OVER phase.
                        w_phase_nx     = PH_OVER;
                        w_time_left_nx = '0;
                        if (w_score_nx > r_high_score) begin
                            w_high_score_nx = w_score_nx;
                            w_new_record_nx = 1'b1;
                        end else begin
                            w_new_record_nx = 1'b0;
                        end
                    end
                end
            end

            default: begin
                w_phase_nx = PH_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign phase       = r_phase;
    assign time_left   = r_time_left;
    assign score       = r_score;
    assign high_score  = r_high_score;
    assign new_record  = r_new_record;
    assign level_fast  = r_level_fast;
    assign mole_enable = (r_phase == PH_PLAY);

    always_comb begin
        display_value = '0;
        case (r_phase)
            PH_IDLE:      display_value = 32'(r_high_score);
            PH_COUNTDOWN: display_value = 32'(r_time_left);
            PH_PLAY:      display_value = 32'(r_score);
            PH_OVER:      display_value = 32'(r_score);
            default:      display_value = '0;
        endcase
    end

endmodule : game_sequencer

`default_nettype wire

// File: tb/tb_game_sequencer.sv
// ============================================================================
// Module      : tb_game_sequencer
// Description : Directed self-checking bench for game_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_game_sequencer;

    // Main instance: default parameters
    logic        clk;
    logic        reset;
    logic        start;
    logic        tick_1hz;
    logic        hit;
    logic        level_select;
    logic [1:0]  phase;
    logic [5:0]  time_left;
    logic [15:0] score;
    logic [15:0] high_score;
    logic        new_record;
    logic        mole_enable;
    logic        level_fast;
    logic [31:0] display_value;

    // Narrow instance: 4-bit score, 1 s countdown
    logic        reset4;
    logic        start4;
    logic        tick4;
    logic        hit4;
    logic        level4;
    logic [1:0]  phase4;
    logic [5:0]  time_left4;
    logic [3:0]  score4;
    logic [3:0]  high_score4;
    logic        new_record4;
    logic        mole_enable4;
    logic        level_fast4;
    logic [31:0] display_value4;

    int n_pass;
    int n_total;

    game_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .tick_1hz      (tick_1hz),
        .hit           (hit),
        .level_select  (level_select),
        .phase         (phase),
        .time_left     (time_left),
        .score         (score),
        .high_score    (high_score),
        .new_record    (new_record),
        .mole_enable   (mole_enable),
        .level_fast    (level_fast),
        .display_value (display_value)
    );

    game_sequencer #(
        .COUNTDOWN_S (1),
        .GAME_S      (30),
        .SCORE_W     (4)
    ) dut4 (
        .clk           (clk),
        .reset         (reset4),
        .start         (start4),
        .tick_1hz      (tick4),
        .hit           (hit4),
        .level_select  (level4),
        .phase         (phase4),
        .time_left     (time_left4),
        .score         (score4),
        .high_score    (high_score4),
        .new_record    (new_record4),
        .mole_enable   (mole_enable4),
        .level_fast    (level_fast4),
        .display_value (display_value4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp_v);
        end
    endtask

    task automatic pulse_tick();
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
    endtask

    task automatic pulse_hit();
        hit = 1'b1;
        step();
        hit = 1'b0;
    endtask

    task automatic press_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, " phase"},       32'(phase),         32'd0);
        chk({tag, " time_left"},   32'(time_left),     32'd0);
        chk({tag, " score"},       32'(score),         32'd0);
        chk({tag, " high_score"},  32'(high_score),    32'd0);
        chk({tag, " new_record"},  32'(new_record),    32'd0);
        chk({tag, " mole_enable"}, 32'(mole_enable),   32'd0);
        chk({tag, " level_fast"},  32'(level_fast),    32'd0);
        chk({tag, " display"},     display_value,      32'd0);
    endtask

    initial begin
        n_pass       = 0;
        n_total      = 0;
        reset        = 1'b0;
        start        = 1'b1;   // held through reset release
        tick_1hz     = 1'b0;
        hit          = 1'b0;
        level_select = 1'b0;
        reset4       = 1'b0;
        start4       = 1'b0;
        tick4        = 1'b0;
        hit4         = 1'b0;
        level4       = 1'b0;

        repeat (3) step();
        check_reset_state("rst");

        // Start held through reset release must not trigger
        reset = 1'b1;
        step();
        step();
        chk("held_start phase", 32'(phase), 32'd0);
        start = 1'b0;
        step();

        // Hit in IDLE ignored
        pulse_hit();
        chk("idle_hit score", 32'(score), 32'd0);

        // Start: IDLE -> COUNTDOWN with time_left=5
        press_start();
        chk("start phase",     32'(phase),     32'd1);
        chk("start time_left", 32'(time_left), 32'd5);
        chk("start display",   display_value,  32'd5);
        chk("start mole_en",   32'(mole_enable), 32'd0);

        // Start pulse and hit during COUNTDOWN are ignored
        step();
        press_start();
        chk("cd_start phase", 32'(phase),     32'd1);
        chk("cd_start time",  32'(time_left), 32'd5);
        pulse_hit();
        chk("cd_hit score",   32'(score),     32'd0);

        // Countdown 5 -> 1, then PLAY with 30
        for (int i = 4; i >= 1; i--) begin
            pulse_tick();
            chk("cd time_left", 32'(time_left), 32'(i));
            chk("cd display",   display_value,  32'(i));
        end
        pulse_tick();
        chk("play phase",     32'(phase),       32'd2);
        chk("play time_left", 32'(time_left),   32'd30);
        chk("play display",   display_value,    32'd0);
        chk("play mole_en",   32'(mole_enable), 32'd1);

        // Start pulse in PLAY ignored
        press_start();
        step();
        chk("play_start phase", 32'(phase),     32'd2);
        chk("play_start time",  32'(time_left), 32'd30);

        // Six slow hits
        for (int i = 0; i < 6; i++) begin
            pulse_hit();
            step();
        end
        chk("slow6 score",   32'(score),    32'd6);
        chk("slow6 display", display_value, 32'd6);

        // 29 ticks: time 30 -> 1
        repeat (29) pulse_tick();
        chk("play29 time_left", 32'(time_left), 32'd1);
        chk("play29 phase",     32'(phase),     32'd2);

        // Final tick with a coincident hit
        hit      = 1'b1;
        tick_1hz = 1'b1;
        step();
        hit      = 1'b0;
        tick_1hz = 1'b0;
        chk("over phase",      32'(phase),       32'd3);
        chk("over score",      32'(score),       32'd7);
        chk("over high_score", 32'(high_score),  32'd7);
        chk("over new_record", 32'(new_record),  32'd1);
        chk("over mole_en",    32'(mole_enable), 32'd0);
        chk("over time_left",  32'(time_left),   32'd0);
        chk("over display",    display_value,    32'd7);

        // Hit in OVER ignored
        pulse_hit();
        chk("over_hit score", 32'(score), 32'd7);

        // Replay in fast mode, tick coincident with start is ignored
        level_select = 1'b1;
        start        = 1'b1;
        tick_1hz     = 1'b1;
        step();
        start        = 1'b0;
        tick_1hz     = 1'b0;
        level_select = 1'b0;
        chk("replay phase",      32'(phase),      32'd1);
        chk("replay time_left",  32'(time_left),  32'd5);
        chk("replay score",      32'(score),      32'd0);
        chk("replay new_record", 32'(new_record), 32'd0);
        chk("replay level_fast", 32'(level_fast), 32'd1);
        chk("replay high_score", 32'(high_score), 32'd7);

        repeat (5) pulse_tick();
        chk("replay play", 32'(phase), 32'd2);
        repeat (3) pulse_hit();
        chk("fast3 score", 32'(score), 32'd6);
        repeat (30) pulse_tick();
        chk("over2 phase",      32'(phase),      32'd3);
        chk("over2 score",      32'(score),      32'd6);
        chk("over2 high_score", 32'(high_score), 32'd7);
        chk("over2 new_record", 32'(new_record), 32'd0);
        chk("over2 display",    display_value,   32'd6);

        // Back in a game, then reset mid-PLAY
        press_start();
        chk("game3 phase", 32'(phase), 32'd1);
        repeat (5) pulse_tick();
        repeat (2) pulse_hit();
        chk("game3 score", 32'(score), 32'd2);
        reset = 1'b0;
        step();
        check_reset_state("midreset");
        reset = 1'b1;
        step();
        chk("after_reset phase", 32'(phase), 32'd0);

        // Narrow instance: saturation at 15 in fast mode
        reset4 = 1'b1;
        step();
        level4 = 1'b1;
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        level4 = 1'b0;
        chk("sat cd phase", 32'(phase4),     32'd1);
        chk("sat cd time",  32'(time_left4), 32'd1);
        tick4 = 1'b1;
        step();
        tick4 = 1'b0;
        chk("sat play phase", 32'(phase4), 32'd2);
        for (int i = 0; i < 9; i++) begin
            hit4 = 1'b1;
            step();
        end
        hit4 = 1'b0;
        chk("sat score",   32'(score4),    32'd15);
        chk("sat display", display_value4, 32'd15);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_game_sequencer

`default_nettype wire
